// File: rtl/mux_seq_if.sv
// Output beat bundle for mux_seq: registered sample, its channel index
// and the valid/ready pair. master = mux_seq side, slave = consumer side.
interface mux_seq_if #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 4
);
  logic [WIDTH-1:0] out_data;
  logic [SEL_W-1:0] out_ch;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output out_data,
    output out_ch,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_ch,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/mux_seq.sv
// Registered N-to-1 mux with direct select and dwell-timed channel scan.
// Ports: clk, rst_n, in_data, mode/sel/sel_load, start/cont/dwell, abort,
// o (beat: out_data/out_ch/out_valid/out_ready), busy, done.
module mux_seq #(
  parameter int N_IN    = 14,
  parameter int WIDTH   = 16,
  parameter int DWELL_W = 8,
  localparam int SEL_W  = $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  sel_load,
  input  logic                  start,
  input  logic                  cont,
  input  logic [DWELL_W-1:0]    dwell,
  input  logic                  abort,
  mux_seq_if.master             o,
  output logic                  busy,
  output logic                  done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;

  localparam logic [SEL_W-1:0] LAST = SEL_W'(N_IN - 1);

  logic [1:0]         state, state_n;
  logic [SEL_W-1:0]   ch, ch_n;
  logic [DWELL_W-1:0] cnt, cnt_n;
  logic [DWELL_W-1:0] dwell_q, dwell_n;
  logic               cont_q, cont_n;
  logic               scan_q, scan_n;
  logic [WIDTH-1:0]   data_q;
  logic [SEL_W-1:0]   och_q;
  logic               valid_q;
  logic               busy_q;
  logic               done_q, done_n;

  logic               smp;
  logic [SEL_W-1:0]   smp_idx;
  logic [WIDTH-1:0]   smp_data;
  logic [SEL_W-1:0]   nxt_ch;
  logic               acc;

  // Out-of-range indices fall through to zero.
  always_comb begin
    smp_data = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (smp_idx == SEL_W'(k)) begin
        smp_data = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign acc    = valid_q && o.out_ready;
  assign nxt_ch = (ch == LAST) ? '0 : ch + SEL_W'(1);

  always_comb begin
    state_n = state;
    ch_n    = ch;
    cnt_n   = cnt;
    dwell_n = dwell_q;
    cont_n  = cont_q;
    scan_n  = scan_q;
    done_n  = 1'b0;
    smp     = 1'b0;
    smp_idx = ch;
    if (abort) begin
      state_n = S_IDLE;
    end else begin
      unique case (1'b1)
        (state == S_IDLE): begin
          if (!mode && sel_load) begin
            ch_n    = sel;
            scan_n  = 1'b0;
            smp     = 1'b1;
            smp_idx = sel;
            state_n = S_EMIT;
          end else if (mode && start) begin
            ch_n    = '0;
            cont_n  = cont;
            dwell_n = dwell;
            cnt_n   = dwell;
            scan_n  = 1'b1;
            if (dwell == '0) begin
              smp     = 1'b1;
              smp_idx = '0;
              state_n = S_EMIT;
            end else begin
              state_n = S_WAIT;
            end
          end
        end
        (state == S_WAIT): begin
          cnt_n = cnt - DWELL_W'(1);
          if (cnt <= DWELL_W'(1)) begin
            cnt_n   = '0;
            smp     = 1'b1;
            smp_idx = ch;
            state_n = S_EMIT;
          end
        end
        (state == S_EMIT): begin
          if (acc) begin
            if (!scan_q) begin
              if (sel_load && !mode) begin
                ch_n    = sel;
                smp     = 1'b1;
                smp_idx = sel;
              end else begin
                state_n = S_IDLE;
              end
            end else if (ch == LAST && !cont_q) begin
              state_n = S_IDLE;
              done_n  = 1'b1;
            end else begin
              ch_n  = nxt_ch;
              cnt_n = dwell_q;
              if (dwell_q == '0) begin
                smp     = 1'b1;
                smp_idx = nxt_ch;
              end else begin
                state_n = S_WAIT;
              end
            end
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      ch      <= '0;
      cnt     <= '0;
      dwell_q <= '0;
      cont_q  <= 1'b0;
      scan_q  <= 1'b0;
      data_q  <= '0;
      och_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      ch      <= ch_n;
      cnt     <= cnt_n;
      dwell_q <= dwell_n;
      cont_q  <= cont_n;
      scan_q  <= scan_n;
      valid_q <= (state_n == S_EMIT);
      busy_q  <= (state_n != S_IDLE);
      done_q  <= done_n;
      if (smp) begin
        data_q <= smp_data;
        och_q  <= smp_idx;
      end
    end
  end

  assign o.out_data  = data_q;
  assign o.out_ch    = och_q;
  assign o.out_valid = valid_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: doc/mux_seq.md
# mux_seq

Parametrised, registered N-to-1 multiplexer for the register bank. Supports two modes: direct single-channel selection, and an automatic scan that walks every channel with a programmable dwell. Each selected sample is delivered as one beat on a valid/ready output, with its channel index, so downstream logic can stall the read path without losing data. It replaces the fixed 14x16 combinational selector in bank read-out paths.

## Interface
- N_IN, 14, number of input channels (2..64)
- WIDTH, 16, bits per channel
- DWELL_W, 8, width of the dwell counter
- SEL_W (localparam), $clog2(N_IN), channel index width
- clk  in  1  rising-edge clock; the only clock
- rst_n  in  1  asynchronous, active-low reset
- in_data  in  N_IN*WIDTH  flattened inputs; channel k occupies bits [k*WIDTH +: WIDTH]
- mode  in  1  0 = direct, 1 = scan; sampled only in IDLE
- sel  in  SEL_W  channel for direct mode
- sel_load  in  1  direct-mode request for one sample of sel
- start  in  1  scan-mode request to begin a scan at channel 0
- cont  in  1  scan wraps continuously when 1; sampled with start
- dwell  in  DWELL_W  wait cycles before each scan sample; sampled with start
- abort  in  1  return to IDLE from any state
- out_data  out  WIDTH  registered sample
- out_ch  out  SEL_W  channel index of out_data
- out_valid  out  1  beat present
- out_ready  in  1  downstream accepts the beat when high with out_valid
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when a non-continuous scan completes

## Operation
- States: IDLE, WAIT, EMIT.
- IDLE, mode=0, sel_load=1:
  - latch sel into ch and sample in_data[ch] into out_data.
  - set out_ch=ch and go to EMIT.
- IDLE, mode=1, start=1:
  - ch=0; latch cont; cnt=dwell.
  - If dwell==0, sample immediately and go to EMIT; else go to WAIT.
- IDLE: start in mode 0 and sel_load in mode 1 are ignored.
- WAIT: cnt decrements each cycle; at cnt==1 the next edge samples in_data[ch] and moves to EMIT.
- EMIT: out_valid=1; out_data and out_ch hold stable until out_valid && out_ready.
- On acceptance in direct mode:
  - return to IDLE.
  - If sel_load=1 and mode=0 in the same cycle, load the new sample instead and stay in EMIT. This gives back-to-back beats.
- On acceptance in scan mode:
  - If ch==N_IN-1 and latched cont==0, go to IDLE and pulse done.
  - Otherwise ch = (ch==N_IN-1) ? 0 : ch+1, cnt=dwell, then go to WAIT; if dwell==0, sample and stay in EMIT.
- sel >= N_IN (only possible when N_IN is not a power of 2): out_data=0, out_ch=sel; the beat is still emitted.
- abort:
  - Wins over every other input, including simultaneous start or sel_load.
  - Next state IDLE; out_valid deasserts on the next edge even if the beat was unaccepted.
  - done is not pulsed; out_data and out_ch keep their last values.
- in_data is sampled only on a sample edge; later input changes never alter a held beat.
- mode, sel, cont and dwell changes while busy have no effect on the operation in progress.

## Timing
- Reset (asynchronous, immediate): state=IDLE, out_data=0, out_ch=0, out_valid=0, busy=0, done=0, ch=0, cnt=0.
- Reset mid-EMIT drops out_valid immediately, without waiting for a clock edge.
- Direct latency: sel_load at edge n gives out_valid=1 from cycle n+1.
- Direct throughput: one beat per cycle when out_ready is held high and sel_load is asserted each cycle.
- Scan latency: start at edge n gives the first out_valid at cycle n+1+dwell.
- Scan spacing: with out_ready=1, consecutive beats are dwell+1 cycles apart. With dwell=0, beats arrive every cycle.
- done is high in the cycle after acceptance of channel N_IN-1, together with busy=0.
- busy is a registered copy of the state; it is high in the cycle after sel_load or start.
- out_ready low stalls indefinitely; the dwell counter does not run during EMIT.

## Test plan
All scenarios use N_IN=14, WIDTH=16, in_data channel k = 16'hA000+k.
- Reset: hold rst_n=0, drive sel_load=1 -> out_valid=0, out_data=0, busy=0. Release rst_n -> no beat until a new sel_load.
- Direct mode, sel=5, sel_load for 1 cycle, out_ready=1 -> one beat 16'hA005 with out_ch=5 the next cycle. Then sel=13 -> 16'hA00D. Then sel=14 -> 16'h0000 with out_ch=14.
- Direct back-to-back:
  - sel_load=1 every cycle with sel=0,1,2, out_ready=1 -> beats A000, A001, A002 on consecutive cycles.
  - Repeat with out_ready=0 for 3 cycles -> A000 holds, and a sel_load during the stall gives a new beat only on the accept cycle.
- Scan, dwell=2, cont=0, out_ready=1:
  - 14 beats A000..A00D, first at start+3, spaced 3 cycles.
  - done pulses once after A00D; busy=0 afterwards.
- Scan, dwell=0, cont=1 with random out_ready -> sequence A000..A00D, A000, ... with no loss or duplication, and no done. Assert abort mid-EMIT -> out_valid=0 next cycle, busy=0, no done.
- Simultaneous events:
  - start and abort together in IDLE -> stays IDLE.
  - Async rst_n pulse during WAIT of channel 7 -> all outputs at reset values immediately; a new start restarts at channel 0.
